// File: rtl/alu_pkg.sv
// Shared opcode / ALUCtrl definitions for the ALU issue path.
// Decode helper returns {illegal, ctrl}.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;

  localparam logic [2:0] CTRL_PASS = 3'b000;
  localparam logic [2:0] CTRL_SUM  = 3'b001;
  localparam logic [2:0] CTRL_SUB  = 3'b010;
  localparam logic [2:0] CTRL_AND  = 3'b011;
  localparam logic [2:0] CTRL_OR   = 3'b100;
  localparam logic [2:0] CTRL_XOR  = 3'b101;
  localparam logic [2:0] CTRL_MUL  = 3'b110;

  // Opcode to {illegal, ALUCtrl}; unknown opcodes pass data1.
  function automatic logic [3:0] decode_op(
    input logic [3:0] op
  );
    logic [3:0] r;
    r = {1'b1, CTRL_PASS};
    unique case (1'b1)
      (op == OP_ADD): r = {1'b0, CTRL_SUM};
      (op == OP_SUB): r = {1'b0, CTRL_SUB};
      (op == OP_AND): r = {1'b0, CTRL_AND};
      (op == OP_OR):  r = {1'b0, CTRL_OR};
      (op == OP_XOR): r = {1'b0, CTRL_XOR};
      (op == OP_MUL): r = {1'b0, CTRL_MUL};
      (op == OP_MOV): r = {1'b0, CTRL_PASS};
      default:        r = {1'b1, CTRL_PASS};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_hs_if.sv
// Generic valid/ready handshake bundle.
// snk: consumer view, src: producer view.
interface alu_hs_if #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport snk (
    input  valid,
    input  data,
    output ready
  );

  modport src (
    output valid,
    output data,
    input  ready
  );
endinterface

// File: rtl/alu_skid_fifo.sv
// 2-entry valid/ready FIFO, payload width W.
// Ready depends on occupancy only; flush empties it.
module alu_skid_fifo #(
  parameter int W = 8
) (
  input logic   clk_i,
  input logic   rst_n_i,
  input logic   flush_i,
  alu_hs_if.snk enq,
  alu_hs_if.src deq
);

  logic [W-1:0] mem_q [2];
  logic         rptr_q;
  logic         wptr_q;
  logic [1:0]   cnt_q;
  logic         push;
  logic         pop;

  assign enq.ready = ~cnt_q[1];
  assign deq.valid = (cnt_q != 2'd0);
  assign deq.data  = mem_q[rptr_q];

  assign push = enq.valid & ~cnt_q[1];
  assign pop  = deq.ready & (cnt_q != 2'd0);

  // Pointer/count bookkeeping and storage write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= 2'd0;
      rptr_q   <= 1'b0;
      wptr_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (flush_i) begin
      cnt_q  <= 2'd0;
      rptr_q <= 1'b0;
      wptr_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= enq.data;
        wptr_q        <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the ALU: decode, 2-entry buffer, writeback regs.
// Optional result forwarding under ALU_ISSUE_FWD_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [TAG_W-1:0]  rd_i,
`ifdef ALU_ISSUE_FWD_EN
  input  logic [TAG_W-1:0]  rs1_i,
  input  logic [TAG_W-1:0]  rs2_i,
`endif
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [2:0]        ALUCtrl_o,
  output logic              alu_valid_o,
  input  logic              alu_ready_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              alu_zero_i,
  output logic              wb_valid_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_zero_o,
  output logic [TAG_W-1:0]  wb_rd_o,
  output logic              illegal_o
);

  localparam int BASE_W = 2 * DATA_W + 3 + TAG_W;
`ifdef ALU_ISSUE_FWD_EN
  localparam int PW = BASE_W + 2 * TAG_W;
`else
  localparam int PW = BASE_W;
`endif

  alu_hs_if #(.W(PW)) enq_if ();
  alu_hs_if #(.W(PW)) deq_if ();

  logic [3:0]        dec;
  logic              fire;
  logic [DATA_W-1:0] h_src1;
  logic [DATA_W-1:0] h_src2;
  logic [2:0]        h_ctrl;
  logic [TAG_W-1:0]  h_rd;
  logic [DATA_W-1:0] opnd1;
  logic [DATA_W-1:0] opnd2;

  logic [DATA_W-1:0] last_d1_q;
  logic [DATA_W-1:0] last_d2_q;
  logic [2:0]        last_ctrl_q;

  logic              wb_valid_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              wb_zero_q;
  logic [TAG_W-1:0]  wb_rd_q;
  logic              illegal_q;

  assign dec = decode_op(op_i);

  assign enq_if.valid = in_valid_i;
`ifdef ALU_ISSUE_FWD_EN
  assign enq_if.data = {rs2_i, rs1_i, rd_i, dec[2:0],
                        src2_i, src1_i};
`else
  assign enq_if.data = {rd_i, dec[2:0], src2_i, src1_i};
`endif
  assign in_ready_o = enq_if.ready;

  assign deq_if.ready = alu_ready_i;
  assign alu_valid_o  = deq_if.valid;
  assign fire         = deq_if.valid & alu_ready_i;

  alu_skid_fifo #(.W(PW)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush_i),
    .enq     (enq_if),
    .deq     (deq_if)
  );

  assign h_src1 = deq_if.data[DATA_W-1:0];
  assign h_src2 = deq_if.data[2*DATA_W-1:DATA_W];
  assign h_ctrl = deq_if.data[2*DATA_W+2:2*DATA_W];
  assign h_rd   = deq_if.data[BASE_W-1:2*DATA_W+3];

`ifdef ALU_ISSUE_FWD_EN
  logic [TAG_W-1:0] h_rs1;
  logic [TAG_W-1:0] h_rs2;
  logic             fwd_vld_q;

  assign h_rs1 = deq_if.data[BASE_W+TAG_W-1:BASE_W];
  assign h_rs2 = deq_if.data[PW-1:BASE_W+TAG_W];

  assign opnd1 = (fwd_vld_q && h_rs1 != '0 && h_rs1 == wb_rd_q)
               ? wb_data_q : h_src1;
  assign opnd2 = (fwd_vld_q && h_rs2 != '0 && h_rs2 == wb_rd_q)
               ? wb_data_q : h_src2;

  // Forward window opens on each dequeue, closes on flush.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fwd_vld_q <= 1'b0;
    end else if (flush_i) begin
      fwd_vld_q <= 1'b0;
    end else if (fire) begin
      fwd_vld_q <= 1'b1;
    end
  end
`else
  assign opnd1 = h_src1;
  assign opnd2 = h_src2;
`endif

  assign data1_o   = deq_if.valid ? opnd1  : last_d1_q;
  assign data2_o   = deq_if.valid ? opnd2  : last_d2_q;
  assign ALUCtrl_o = deq_if.valid ? h_ctrl : last_ctrl_q;

  // Remember the last presented operands so an empty FIFO holds them.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_d1_q   <= '0;
      last_d2_q   <= '0;
      last_ctrl_q <= CTRL_PASS;
    end else if (deq_if.valid) begin
      last_d1_q   <= opnd1;
      last_d2_q   <= opnd2;
      last_ctrl_q <= h_ctrl;
    end
  end

  // Capture ALU result on dequeue; a flushed dequeue is dropped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_zero_q  <= 1'b0;
      wb_rd_q    <= '0;
    end else if (flush_i) begin
      wb_valid_q <= 1'b0;
    end else begin
      wb_valid_q <= fire;
      if (fire) begin
        wb_data_q <= alu_data_i;
        wb_zero_q <= alu_zero_i;
        wb_rd_q   <= h_rd;
      end
    end
  end

  // One-cycle illegal-opcode pulse after acceptance.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= ~flush_i & in_valid_i & enq_if.ready & dec[3];
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_data_o  = wb_data_q;
  assign wb_zero_o  = wb_zero_q;
  assign wb_rd_o    = wb_rd_q;
  assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU attached.
// Forwarding checks are built when ALU_ISSUE_FWD_EN is defined.
module tb_alu_issue_stage;

  localparam int DW = 32;
  localparam int TW = 5;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [3:0]    op_i = '0;
  logic [DW-1:0] src1_i = '0;
  logic [DW-1:0] src2_i = '0;
  logic [TW-1:0] rd_i = '0;
`ifdef ALU_ISSUE_FWD_EN
  logic [TW-1:0] rs1_i = '0;
  logic [TW-1:0] rs2_i = '0;
`endif
  logic [DW-1:0] data1_o;
  logic [DW-1:0] data2_o;
  logic [2:0]    ALUCtrl_o;
  logic          alu_valid_o;
  logic          alu_ready_i = 1'b0;
  logic [DW-1:0] alu_data_i;
  logic          alu_zero_i;
  logic          wb_valid_o;
  logic [DW-1:0] wb_data_o;
  logic          wb_zero_o;
  logic [TW-1:0] wb_rd_o;
  logic          illegal_o;

  typedef struct {
    logic [DW-1:0] d;
    logic          z;
    logic [TW-1:0] rd;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  alu_issue_stage #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .rd_i        (rd_i),
`ifdef ALU_ISSUE_FWD_EN
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
`endif
    .data1_o     (data1_o),
    .data2_o     (data2_o),
    .ALUCtrl_o   (ALUCtrl_o),
    .alu_valid_o (alu_valid_o),
    .alu_ready_i (alu_ready_i),
    .alu_data_i  (alu_data_i),
    .alu_zero_i  (alu_zero_i),
    .wb_valid_o  (wb_valid_o),
    .wb_data_o   (wb_data_o),
    .wb_zero_o   (wb_zero_o),
    .wb_rd_o     (wb_rd_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural ALU driven by the stage outputs
  always_comb begin
    alu_data_i = data1_o;
    case (ALUCtrl_o)
      3'b001:  alu_data_i = data1_o + data2_o;
      3'b010:  alu_data_i = data1_o - data2_o;
      3'b011:  alu_data_i = data1_o & data2_o;
      3'b100:  alu_data_i = data1_o | data2_o;
      3'b101:  alu_data_i = data1_o ^ data2_o;
      3'b110:  alu_data_i = data1_o * data2_o;
      default: alu_data_i = data1_o;
    endcase
  end
  assign alu_zero_i = (alu_data_i == '0);

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every writeback pulse pops one expectation
  always @(negedge clk_i) begin
    if (rst_n_i && wb_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected got data=%0h rd=%0d want none",
                 wb_data_o, wb_rd_o);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_data", 64'(wb_data_o), 64'(e.d));
        chk("wb_zero", 64'(wb_zero_o), 64'(e.z));
        chk("wb_rd", 64'(wb_rd_o), 64'(e.rd));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one op, wait for acceptance, optionally expect a writeback
  task automatic send(input logic [3:0] op, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [TW-1:0] rd,
                      input bit push, input logic [DW-1:0] ed,
                      input bit ez);
    int guard;
    wb_t e;
    in_valid_i = 1'b1;
    op_i = op;
    src1_i = a;
    src2_i = b;
    rd_i = rd;
    guard = 0;
    while (!in_ready_o && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=stalled want=accept");
    end else if (push) begin
      e.d = ed;
      e.z = ez;
      e.rd = rd;
      exp_q.push_back(e);
    end
    tick();
    in_valid_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    chk("rst_alu_valid", 64'(alu_valid_o), 64'd0);
    chk("rst_data1", 64'(data1_o), 64'd0);
    chk("rst_ctrl", 64'(ALUCtrl_o), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_illegal", 64'(illegal_o), 64'd0);
    tick();

    // Single ADD, no backpressure
    alu_ready_i = 1'b1;
    send(4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 32'd12, 1'b0);
    chk("add_ctrl", 64'(ALUCtrl_o), 64'b001);
    chk("add_alu_valid", 64'(alu_valid_o), 64'd1);
    tick();
    tick();

    // Backpressure: two fill the FIFO, third waits upstream
    alu_ready_i = 1'b0;
    send(4'd0, 32'd1, 32'd2, 5'd1, 1'b1, 32'd3, 1'b0);
    send(4'd3, 32'hF0, 32'h0F, 5'd2, 1'b1, 32'hFF, 1'b0);
    chk("full_ready", 64'(in_ready_o), 64'd0);
    in_valid_i = 1'b1;
    op_i = 4'd4;
    src1_i = 32'hFF;
    src2_i = 32'h0F;
    rd_i = 5'd5;
    repeat (2) tick();
    chk("held_ready", 64'(in_ready_o), 64'd0);
    chk("held_head_ctrl", 64'(ALUCtrl_o), 64'b001);
    chk("held_head_d1", 64'(data1_o), 64'd1);
    alu_ready_i = 1'b1;
    send(4'd4, 32'hFF, 32'h0F, 5'd5, 1'b1, 32'hF0, 1'b0);
    repeat (4) tick();

    // Zero flag, truncated multiply, AND, MOV
    send(4'd1, 32'd9, 32'd9, 5'd6, 1'b1, 32'd0, 1'b1);
    send(4'd5, 32'h10000, 32'h10000, 5'd7, 1'b1, 32'd0, 1'b1);
    send(4'd2, 32'hC, 32'hA, 5'd8, 1'b1, 32'd8, 1'b0);
    send(4'd6, 32'h77, 32'h5, 5'd9, 1'b1, 32'h77, 1'b0);
    repeat (3) tick();

    // Illegal opcode: pulse once, still issued as pass-through
    send(4'd9, 32'h1234, 32'h55, 5'd10, 1'b1, 32'h1234, 1'b0);
    chk("ill_pulse", 64'(illegal_o), 64'd1);
    chk("ill_ctrl", 64'(ALUCtrl_o), 64'd0);
    tick();
    chk("ill_pulse_end", 64'(illegal_o), 64'd0);
    repeat (2) tick();

    // Flush with 1 or 2 buffered ops, enqueue and dequeue same cycle
    for (int n = 1; n <= 2; n++) begin
      alu_ready_i = 1'b0;
      for (int k = 0; k < n; k++)
        send(4'd0, 32'd1, 32'(k), 5'd11, 1'b0, 32'd0, 1'b0);
      chk("pre_flush_valid", 64'(alu_valid_o), 64'd1);
      in_valid_i = 1'b1;
      op_i = 4'd12;
      src1_i = 32'd3;
      src2_i = 32'd3;
      rd_i = 5'd13;
      flush_i = 1'b1;
      alu_ready_i = 1'b1;
      tick();
      flush_i = 1'b0;
      in_valid_i = 1'b0;
      chk("flush_alu_valid", 64'(alu_valid_o), 64'd0);
      chk("flush_in_ready", 64'(in_ready_o), 64'd1);
      chk("flush_wb_valid", 64'(wb_valid_o), 64'd0);
      chk("flush_illegal", 64'(illegal_o), 64'd0);
      repeat (3) tick();
    end

    // Asynchronous reset between edges
    alu_ready_i = 1'b0;
    send(4'd0, 32'd2, 32'd2, 5'd14, 1'b0, 32'd0, 1'b0);
    @(posedge clk_i);
    #3 rst_n_i = 1'b0;
    #1;
    chk("arst_alu_valid", 64'(alu_valid_o), 64'd0);
    chk("arst_in_ready", 64'(in_ready_o), 64'd1);
    chk("arst_data1", 64'(data1_o), 64'd0);
    chk("arst_ctrl", 64'(ALUCtrl_o), 64'd0);
    chk("arst_wb_data", 64'(wb_data_o), 64'd0);
    chk("arst_wb_rd", 64'(wb_rd_o), 64'd0);
    chk("arst_wb_valid", 64'(wb_valid_o), 64'd0);
    tick();
    rst_n_i = 1'b1;
    alu_ready_i = 1'b1;
    repeat (2) tick();
    chk("post_rst_valid", 64'(alu_valid_o), 64'd0);
    send(4'd0, 32'd100, 32'd23, 5'd10, 1'b1, 32'd123, 1'b0);
    repeat (3) tick();

`ifdef ALU_ISSUE_FWD_EN
    // Forward last result into rs1; tag 0 must not forward
    send(4'd0, 32'd5, 32'd7, 5'd4, 1'b1, 32'd12, 1'b0);
    rs1_i = 5'd4;
    send(4'd0, 32'd99, 32'd1, 5'd15, 1'b1, 32'd13, 1'b0);
    chk("fwd_data1", 64'(data1_o), 64'd12);
    rs1_i = 5'd0;
    repeat (3) tick();
    send(4'd0, 32'd5, 32'd7, 5'd0, 1'b1, 32'd12, 1'b0);
    send(4'd0, 32'd99, 32'd1, 5'd16, 1'b1, 32'd100, 1'b0);
    chk("nofwd_data1", 64'(data1_o), 64'd99);
    repeat (3) tick();
`endif

    repeat (3) tick();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Pipeline stage that sits directly upstream of the ALU. It accepts decoded operation requests over a valid/ready handshake and buffers them in a 2-entry skid FIFO. It translates the opcode into the ALU's 3-bit ALUCtrl encoding and presents registered operands and control to the ALU. It also captures the ALU's combinational result into a registered writeback output.

Parameters:
DATA_W, 32, operand/result width (ALU is fixed at 32)
TAG_W, 5, destination register tag width

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush; drops buffered and in-flight ops
in_valid_i  in  1  upstream request valid
in_ready_o  out  1  stage can accept (FIFO not full)
op_i  in  4  opcode
src1_i  in  DATA_W  operand 1
src2_i  in  DATA_W  operand 2
rd_i  in  TAG_W  destination tag
data1_o  out  DATA_W  to ALU data1_i
data2_o  out  DATA_W  to ALU data2_i
ALUCtrl_o  out  3  to ALU ALUCtrl_i
alu_valid_o  out  1  head op presented to ALU
alu_ready_i  in  1  downstream accepts the ALU result this cycle
alu_data_i  in  DATA_W  from ALU data_o
alu_zero_i  in  1  from ALU Zero_o
wb_valid_o  out  1  registered result valid (one-cycle pulse)
wb_data_o  out  DATA_W  registered result
wb_zero_o  out  1  registered zero flag
wb_rd_o  out  TAG_W  registered destination tag
illegal_o  out  1  pulse: an illegal opcode was accepted

Behaviour:
- Clock and reset: one clock `clk_i`; reset `rst_n_i` is asynchronous, active-low. Reset is asserted asynchronously and released synchronously.
- Reset values: FIFO empty; `in_ready_o`=1; `alu_valid_o`=0; `data1_o`/`data2_o`/`ALUCtrl_o`=0; all `wb_*` outputs=0; `illegal_o`=0.
- Opcode decode (`op_i` -> ALUCtrl), done at enqueue and stored in the FIFO:
  - 0 ADD -> 001; 1 SUB -> 010; 2 AND -> 011; 3 OR -> 100; 4 XOR -> 101; 5 MUL -> 110.
  - 6 MOV -> 000 (ALU passes data1 through).
  - 7..15 are illegal -> 000, and `illegal_o` pulses the cycle after acceptance. The op is still issued.
- FIFO: 2 entries, with read pointer, write pointer and 2-bit count.
  - Enqueue when `in_valid_i && in_ready_o`.
  - Dequeue when `alu_valid_o && alu_ready_i`.
  - `in_ready_o` = count<2, registered-free (combinational from count only, no dependency on `alu_ready_i`).
  - Simultaneous enqueue and dequeue when full is not allowed, because `in_ready_o`=0. When count is 1, both happen and count stays 1.
  - Pointers wrap modulo 2.
- ALU outputs:
  - `alu_valid_o` = count!=0.
  - `data1_o`, `data2_o` and `ALUCtrl_o` reflect the FIFO head.
  - When the FIFO is empty they hold their last values; the ALU's data_o is don't-care then.
- Latency: an op accepted in cycle N appears at the ALU in cycle N+1 at the earliest.
- Writeback:
  - On dequeue, `alu_data_i`, `alu_zero_i` and the head tag are registered.
  - `wb_valid_o` pulses 1 in cycle N+2 relative to acceptance when there is no backpressure.
  - The `wb_*` data outputs hold until the next dequeue.
- Flush (`flush_i`=1):
  - Next cycle: count=0, pointers reset to 0, `wb_valid_o`=0, `illegal_o`=0.
  - An enqueue in the same cycle is discarded.
  - A dequeue in the same cycle does not produce `wb_valid_o`.
  - Flush has priority over all other events.
- Reset mid-operation: all state clears immediately; in-flight ops are lost.

Optional Feature:
Macro ALU_ISSUE_FWD_EN enables single-entry result forwarding.
- With the macro:
  - Add inputs `rs1_i` and `rs2_i` (TAG_W each), stored per FIFO entry.
  - At dequeue, the stage records the destination tag plus a forward-valid bit.
  - When the new head's rs1/rs2 equals the last dequeued rd, `data1_o`/`data2_o` are replaced by `wb_data_o`. The forward-valid bit is cleared by flush and reset.
  - Tag 0 never forwards.
- Without the macro: no `rs` ports exist and operands pass through unchanged.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD..OP_MOV;
  - ALUCtrl constants CTRL_SUM=001, CTRL_SUB=010, CTRL_AND=011, CTRL_OR=100, CTRL_XOR=101, CTRL_MUL=110, CTRL_PASS=000;
  - a `decode_op` function returning {illegal, ctrl}.
- One sub-module: `alu_skid_fifo`, a generic 2-entry valid/ready FIFO parameterised by payload width.

Test Plan:
- Reset then ADD src1=5, src2=7, rd=3 with `alu_ready_i`=1 and the ALU attached -> `ALUCtrl_o`=001 at N+1; `wb_valid_o`=1, `wb_data_o`=12, `wb_zero_o`=0, `wb_rd_o`=3 at N+2.
- Three back-to-back ops with `alu_ready_i`=0 -> `in_ready_o` drops to 0 after 2 accepts and the third is held upstream. Releasing ready then drains all three in order.
- SUB 9,9 -> `wb_data_o`=0, `wb_zero_o`=1. MUL 0x10000 by 0x10000 -> `wb_data_o`=0 (truncated to 32 bits).
- op_i=9 -> `illegal_o` pulses once and `ALUCtrl_o`=000. The op is issued and `wb_data_o`=src1.
- Two buffered ops, then `flush_i` together with an enqueue -> next cycle `alu_valid_o`=0, `in_ready_o`=1, no `wb_valid_o`.
- `rst_n_i` low mid-stream (asynchronous, between edges) -> all outputs are at reset values before the next edge.
- With ALU_ISSUE_FWD_EN: ADD rd=4 giving 12, then ADD rs1=4 -> `data1_o`=12. Same sequence with rs1=0 -> no forwarding.
